mux_4_1_scanner: RTL

Upstream sequencer for mux_4_1. It drives the mux select lines across the enabled input channels, waits a programmable dwell time per channel, and samples the mux output y. The sampled bits are assembled into a 4-bit frame, which is delivered downstream over a valid/ready handshake. It supports single-shot and continuous scanning, plus a wrapping frame counter.

---
 rtl/mux_4_1_scanner_if.sv | 24 ++
 rtl/mux_4_1_scanner.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mux_4_1_scanner_if.sv
// Handshake/bus bundle between the mux_4_1 scan sequencer and its environment.
// The slave modport is the scanner; the master modport is the environment driving it.
interface mux_4_1_scanner_if;
  logic       start;
  logic       cont;
  logic [3:0] ch_en;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic [7:0] frame_cnt;

  modport slave (
    input  start, cont, ch_en, y_in, frame_ready,
    output sel, frame, frame_valid, busy, frame_cnt
  );

  modport master (
    output start, cont, ch_en, y_in, frame_ready,
    input  sel, frame, frame_valid, busy, frame_cnt
  );
endinterface

// File: rtl/mux_4_1_scanner.sv
// Scan sequencer for mux_4_1: steps sel over the enabled channels, samples y after a dwell,
// and hands the assembled 4-bit frame downstream over valid/ready.
module mux_4_1_scanner #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input logic               clk,
  input logic               rst,
  mux_4_1_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] RELOAD_C = CW'(DWELL - 1);
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [3:0]    frame_q;
  logic [3:0]    shadow_q;
  logic [3:0]    en_q;
  logic          frame_valid_q;
  logic          busy_q;
  logic [7:0]    frame_cnt_q;
  logic [CW-1:0] cnt_q;

  logic [3:0]    shadow_d;
  logic [2:0]    next_s;
  logic [1:0]    first_s;
  logic          xfer_s;
  logic          accept_s;

  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Returns {found, channel} for the lowest enabled channel strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(cur)) && mask[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Next-sample shadow, channel stepping and handshake/acceptance decode.
  always_comb begin
    shadow_d         = shadow_q;
    shadow_d[sel_q]  = bus.y_in;
    next_s           = next_above(en_q, sel_q);
    first_s          = lowest_ch(bus.ch_en);
    xfer_s           = (state_q == S_DONE) && frame_valid_q && bus.frame_ready;
    accept_s         = (bus.ch_en != 4'b0000) &&
                       (((state_q == S_IDLE) && (bus.start || bus.cont)) ||
                        (xfer_s && bus.cont));
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sel_q         <= 2'd0;
      frame_q       <= 4'd0;
      shadow_q      <= 4'd0;
      en_q          <= 4'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      cnt_q         <= {CW{1'b0}};
    end else begin
      if (xfer_s) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
      // A transfer with cont high restarts here, so back-to-back scans have no IDLE gap.
      if (accept_s) begin
        en_q          <= bus.ch_en;
        shadow_q      <= 4'd0;
        sel_q         <= first_s;
        cnt_q         <= RELOAD_C;
        busy_q        <= 1'b1;
        frame_valid_q <= 1'b0;
        state_q       <= S_DWELL;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_DWELL: begin
            if (cnt_q != {CW{1'b0}}) begin
              cnt_q <= cnt_q - ONE_C;
            end else begin
              shadow_q <= shadow_d;
              if (next_s[2]) begin
                sel_q <= next_s[1:0];
                cnt_q <= RELOAD_C;
              end else begin
                frame_q       <= shadow_d;
                frame_valid_q <= 1'b1;
                state_q       <= S_DONE;
              end
            end
          end
          S_DONE: begin
            if (xfer_s) begin
              frame_valid_q <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else begin
              state_q <= S_DONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
